// File: rtl/hlsm_dataflow_param.sv
// Fixed dataflow kernel (d=a+b, e=a+c, f=a*c, g=a<b; x=f-d, z=g?e+f:e-f) on one ALU plus a multiplier of MUL_LAT cycles.
// Latency: Done rises max(6, MUL_LAT+3) cycles after the accepting Start edge; Start is ignored while Busy (no queueing).
module hlsm_dataflow_param #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_LAT    = 2,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] z
);

    typedef enum logic [2:0] {WAIT, S1, S2, S3, MWAIT, S4, S5, FINAL} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] ar, br, cr;
    logic [DATA_WIDTH-1:0] d, e, f, x_r, z_r;
    logic [DATA_WIDTH-1:0] prod, z_nxt;
    logic                  g, lt;
    logic                  f_valid, f_wr, f_ready;
    logic [3:0]            mul_cnt;

    // Counter is loaded on acceptance, so reaching 1 marks the edge at which f lands.
    assign f_wr    = (mul_cnt == 4'd1);
    assign f_ready = f_valid | f_wr;
    assign prod    = ar * cr;
    assign z_nxt   = g ? (e + f) : (e - f);

    always_comb begin
        lt = 1'b0;
        if (SIGNED)
            lt = $signed(ar) < $signed(br);
        else
            lt = ar < br;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:    if (Start) state_nxt = S1;
            S1:      state_nxt = S2;
            S2:      state_nxt = S3;
            S3:      state_nxt = f_ready ? S4 : MWAIT;
            MWAIT:   state_nxt = f_ready ? S4 : MWAIT;
            S4:      state_nxt = S5;
            S5:      state_nxt = FINAL;
            FINAL:   state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= WAIT;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            x       <= '0;
            z       <= '0;
            ar      <= '0;
            br      <= '0;
            cr      <= '0;
            d       <= '0;
            e       <= '0;
            f       <= '0;
            g       <= 1'b0;
            x_r     <= '0;
            z_r     <= '0;
            f_valid <= 1'b0;
            mul_cnt <= '0;
        end else begin
            state <= state_nxt;
            Busy  <= (state_nxt != WAIT);
            Done  <= (state_nxt == FINAL);

            if (state == WAIT && Start) begin
                ar      <= a;
                br      <= b;
                cr      <= c;
                mul_cnt <= 4'(MUL_LAT);
                f_valid <= 1'b0;
            end else if (mul_cnt != 4'd0) begin
                mul_cnt <= mul_cnt - 4'd1;
            end

            if (f_wr) begin
                f       <= prod;
                f_valid <= 1'b1;
            end

            case (state)
                S1: d <= ar + br;
                S2: e <= ar + cr;
                S3: g <= lt;
                S4: x_r <= f - d;
                // Outputs load on the edge entering FINAL so they are valid alongside Done.
                S5: begin
                    z_r <= z_nxt;
                    x   <= x_r;
                    z   <= z_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hlsm_dataflow_param.sv
// Scoreboard bench: three instances (unsigned/lat 2, signed/lat 2, unsigned/lat 6) driven by directed vectors.
module tb_hlsm_dataflow_param;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] z;
        int           cyc;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic         start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic         busy0, busy1, busy2, done0, done1, done2;
    logic [W-1:0] x0, x1, x2, z0, z1, z2;

    exp_t q0[$], q1[$], q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    hlsm_dataflow_param #(.DATA_WIDTH(W), .MUL_LAT(2), .SIGNED(1'b0)) u0 (
        .Clk(Clk), .Rst(Rst), .Start(start0), .a(a), .b(b), .c(c),
        .Busy(busy0), .Done(done0), .x(x0), .z(z0));
    hlsm_dataflow_param #(.DATA_WIDTH(W), .MUL_LAT(2), .SIGNED(1'b1)) u1 (
        .Clk(Clk), .Rst(Rst), .Start(start1), .a(a), .b(b), .c(c),
        .Busy(busy1), .Done(done1), .x(x1), .z(z1));
    hlsm_dataflow_param #(.DATA_WIDTH(W), .MUL_LAT(6), .SIGNED(1'b0)) u2 (
        .Clk(Clk), .Rst(Rst), .Start(start2), .a(a), .b(b), .c(c),
        .Busy(busy2), .Done(done2), .x(x2), .z(z2));

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_result(input string id, input exp_t e, input logic [W-1:0] xa, input logic [W-1:0] za);
        chk({id, " x"}, xa, e.x);
        chk({id, " z"}, za, e.z);
        chk({id, " Done cycle"}, W'(cyc), W'(e.cyc));
    endtask

    task automatic spurious(input string id);
        n_cmp++;
        n_bad++;
        $display("FAIL %s spurious Done: got Done=1 at cycle %0d want no pending result", id, cyc);
    endtask

    // Monitors: pop an expectation whenever an instance presents Done.
    always @(negedge Clk) begin
        if (done0) begin
            if (q0.size() == 0) spurious("u0");
            else check_result("u0", q0.pop_front(), x0, z0);
        end
        if (done1) begin
            if (q1.size() == 0) spurious("u1");
            else check_result("u1", q1.pop_front(), x1, z1);
        end
        if (done2) begin
            if (q2.size() == 0) spurious("u2");
            else check_result("u2", q2.pop_front(), x2, z2);
        end
    end

    function automatic logic busy_of(input int id);
        case (id)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        @(negedge Clk);
        while (busy_of(id) && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (busy_of(id)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u%0d idle timeout: got Busy=1 want 0 within 50 cycles", id);
        end
    endtask

    // lat = cycles from the accepting edge (counted as 1) to the edge raising Done.
    task automatic go(input int id, input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv,
                      input logic [W-1:0] xe, input logic [W-1:0] ze, input int lat);
        exp_t e;
        wait_idle(id);
        a = av; b = bv; c = cv;
        set_start(id, 1'b1);
        @(negedge Clk);
        set_start(id, 1'b0);
        e.x = xe; e.z = ze; e.cyc = cyc + lat - 1;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    initial begin
        exp_t e;
        int   n;

        repeat (2) @(negedge Clk);
        chk("reset Done", {31'b0, done0}, 32'd0);
        chk("reset Busy", {31'b0, busy0}, 32'd0);
        chk("reset x", x0, 32'd0);
        chk("reset z", z0, 32'd0);
        Rst = 1'b0;

        go(0, 32'd3, 32'd5, 32'd7, 32'd13, 32'd31, 6);
        go(1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 6);
        go(2, 32'd3, 32'd5, 32'd7, 32'd13, 32'd31, 9);
        go(0, 32'd10, 32'd4, 32'd2, 32'd6, 32'hFFFFFFF8, 6);
        go(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFD, 6);
        go(1, 32'd3, 32'd5, 32'd7, 32'd13, 32'd31, 6);
        go(2, 32'd10, 32'd4, 32'd2, 32'd6, 32'hFFFFFFF8, 9);

        // Start pulsed mid-run is ignored; held through FINAL it launches the next run.
        wait_idle(0);
        a = 32'd3; b = 32'd5; c = 32'd7;
        start0 = 1'b1;
        @(negedge Clk);
        start0 = 1'b0;
        n = cyc;
        e.x = 32'd13; e.z = 32'd31; e.cyc = n + 5;
        q0.push_back(e);
        repeat (2) @(negedge Clk);
        a = 32'd10; b = 32'd4; c = 32'd2;
        start0 = 1'b1;
        @(negedge Clk);
        chk("busy after ignored Start", {31'b0, busy0}, 32'd1);
        repeat (3) @(negedge Clk);
        chk("busy in WAIT after FINAL", {31'b0, busy0}, 32'd0);
        e.x = 32'd6; e.z = 32'hFFFFFFF8; e.cyc = n + 12;
        q0.push_back(e);
        @(negedge Clk);
        start0 = 1'b0;
        chk("busy after held Start", {31'b0, busy0}, 32'd1);

        // Reset mid-run on the slow instance, then a fresh run must be clean and on time.
        wait_idle(0);
        wait_idle(1);
        wait_idle(2);
        a = 32'd3; b = 32'd5; c = 32'd7;
        start2 = 1'b1;
        @(negedge Clk);
        start2 = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("mid-run reset Done", {31'b0, done2}, 32'd0);
        chk("mid-run reset Busy", {31'b0, busy2}, 32'd0);
        chk("mid-run reset x", x2, 32'd0);
        chk("mid-run reset z", z2, 32'd0);
        go(2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFD, 9);

        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        repeat (5) @(negedge Clk);
        chk("u0 pending results", W'(q0.size()), 32'd0);
        chk("u1 pending results", W'(q1.size()), 32'd0);
        chk("u2 pending results", W'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hlsm_dataflow_param.md
Name: hlsm_dataflow_param

Overview:
- Parametrised successor to the HLS-generated single-kernel HLSMs.
- Executes a fixed dataflow kernel under a resource-constrained schedule: one ALU, plus one pipelined multiplier of configurable latency.
- Clean Start/Done handshake, synchronous reset, configurable width and signedness.
- Sits as a leaf compute block under a host controller that pulses Start and samples results on Done.

Kernel, all arithmetic mod 2^DATA_WIDTH:
- d = a+b
- e = a+c
- f = a*c
- g = (a<b)
- x = f-d
- z = g ? (e+f) : (e-f)

Parameters:
- DATA_WIDTH, 32, width of a, b, c, x, z and all internal temporaries.
- MUL_LAT, 2, multiplier latency in cycles; legal range 1..8.
- SIGNED, 0, 1 = a<b compares two's-complement signed; 0 = unsigned.

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  level-sampled request, accepted only in WAIT.
- a  input  DATA_WIDTH  operand, captured on acceptance.
- b  input  DATA_WIDTH  operand, captured on acceptance.
- c  input  DATA_WIDTH  operand, captured on acceptance.
- Busy  output  1  high from S1 through FINAL inclusive.
- Done  output  1  one-cycle pulse; x and z valid from this cycle on.
- x  output  DATA_WIDTH  result x, registered.
- z  output  DATA_WIDTH  result z, registered.

Behaviour:
- Reset (Rst=1 at a clock edge): state=WAIT; Done=0, Busy=0, x=0, z=0; all temporaries, operand latches and the multiplier counter = 0. Reset takes priority in every state, including mid-operation; any in-flight multiply is discarded.
- WAIT:
  - If Start=1 at edge T: latch a, b, c into ar, br, cr, then go to S1.
  - Otherwise stay in WAIT.
  - Inputs a/b/c are ignored in every other state.
- S1 (T+1): d <= ar+br on the ALU. Issue multiply ar*cr, loading mul counter with MUL_LAT.
- S2 (T+2): e <= ar+cr.
- S3 (T+3): g <= (ar<br), signed/unsigned per SIGNED.
- Multiplier:
  - f <= low DATA_WIDTH bits of ar*cr, written at the end of cycle T+MUL_LAT.
  - f_valid is set at that same edge.
  - Counter decrements every cycle after issue, independent of state.
- MWAIT: entered from S3 if f_valid=0; holds until f_valid=1. Not entered at all when MUL_LAT<=3.
- S4: entered at cycle max(T+4, T+MUL_LAT+1); x_r <= f-d.
- S5: z_r <= g ? e+f : e-f.
- FINAL:
  - x <= x_r and z <= z_r at entry.
  - Done=1 for exactly this cycle; then go to WAIT.
  - Done cycle = max(T+6, T+MUL_LAT+3); 6 cycles after the Start edge at MUL_LAT=2.
- Outputs x and z hold their last values between runs; they change only on entry to FINAL or on reset.
- Start=1 while Busy=1 is ignored (no queueing).
- Start held continuously: a new run is accepted in the WAIT cycle right after FINAL. Back-to-back throughput is one result per (latency+1) cycles.
- Overflow: add, sub and mul wrap silently. No saturation, no flags.
- Busy is registered: 1 in S1..FINAL, 0 in WAIT.

Test Plan:
- W=32, SIGNED=0, MUL_LAT=2; a=3, b=5, c=7 → d=8, e=10, f=21, g=1; x=13, z=31; Done exactly 6 cycles after the Start edge, for one cycle.
- SIGNED=0; a=10, b=4, c=2 → g=0; x=6, z=0xFFFFFFF8 (e-f wrap).
- a=0xFFFFFFFF, b=1, c=0xFFFFFFFF:
  - SIGNED=0: d=0, e=0xFFFFFFFE, f=1, g=0; x=1, z=0xFFFFFFFD.
  - SIGNED=1: g=1; z=0xFFFFFFFF.
- MUL_LAT=6, a=3, b=5, c=7 → MWAIT visited for 3 cycles; Done at T+9; same x=13, z=31.
- Start pulsed again at cycle T+3 during a run → ignored; Busy stays high; exactly one Done. Start then held high → second run begins in the WAIT cycle after FINAL with newly latched operands.
- Rst asserted at T+3 mid-run → next cycle Done=0, Busy=0, x=0, z=0, state WAIT. A stale multiply never updates f. A fresh Start then gives correct results.
